// File: rtl/canny_pkg.sv
// Shared types and helpers for the Canny Sobel gradient stage.
// THRESHOLD only takes effect when CANNY_THRESH_EN is defined.
package canny_pkg;

    localparam int DATA_W = 16;
    localparam int GRAD_W = DATA_W + 3;

    localparam logic [DATA_W-1:0] THRESHOLD = 16'd128;

    typedef logic signed [GRAD_W-1:0] grad_t;
    typedef logic        [GRAD_W:0]   wide_mag_t;

    // The centre pixel never contributes to a Sobel gradient, so it is not stored.
    typedef struct packed {
        logic [DATA_W-1:0] im11;
        logic [DATA_W-1:0] im12;
        logic [DATA_W-1:0] im13;
        logic [DATA_W-1:0] im21;
        logic [DATA_W-1:0] im23;
        logic [DATA_W-1:0] im31;
        logic [DATA_W-1:0] im32;
        logic [DATA_W-1:0] im33;
    } window_t;

    function automatic logic [DATA_W-1:0] sat_clamp(input wide_mag_t v);
        return (v > wide_mag_t'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/canny_edge_if.sv
// Pixel-window input and gradient-result output bundle for canny_edge.
interface canny_edge_if
    import canny_pkg::*;
();

    logic              start;
    logic [DATA_W-1:0] im11, im21, im31;
    logic [DATA_W-1:0] im12, im22, im32;
    logic [DATA_W-1:0] im13, im23, im33;

    logic [DATA_W-1:0] dx_out;
    logic              dx_out_sign;
    logic [DATA_W-1:0] dy_out;
    logic              dy_out_sign;
    logic [DATA_W-1:0] dxy;
    logic              data_occur;

    modport master (
        output start, im11, im21, im31, im12, im22, im32, im13, im23, im33,
        input  dx_out, dx_out_sign, dy_out, dy_out_sign, dxy, data_occur
    );

    modport slave (
        input  start, im11, im21, im31, im12, im22, im32, im13, im23, im33,
        output dx_out, dx_out_sign, dy_out, dy_out_sign, dxy, data_occur
    );

endinterface

// File: rtl/canny_edge_sobel_kernel.sv
// One Sobel direction: (a + 2b + c) - (d + 2e + f) as a signed GRAD_W value.
module sobel_kernel
    import canny_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] e,
    input  logic [DATA_W-1:0] f,
    output grad_t             g
);

    // Each weighted sum is at most 4*65535, which fits GRAD_W-1 bits, so the
    // difference cannot overflow the signed GRAD_W result.
    logic [GRAD_W-1:0] pos_sum;
    logic [GRAD_W-1:0] neg_sum;

    assign pos_sum = GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
    assign neg_sum = GRAD_W'(d) + (GRAD_W'(e) << 1) + GRAD_W'(f);
    assign g       = grad_t'(pos_sum - neg_sum);

endmodule

// File: rtl/canny_edge.sv
// Three-stage Sobel gradient pipeline: capture window, compute Gx/Gy, magnitude/sign.
// Define CANNY_THRESH_EN to turn dxy into a binary edge decision against THRESHOLD.
module canny_edge
    import canny_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    canny_edge_if.slave  bus
);

    window_t           win_q;
    logic              valid1;
    grad_t             gx, gy;
    grad_t             gx_q, gy_q;
    logic              valid2;
    logic [GRAD_W-1:0] abs_x, abs_y;
    wide_mag_t         mag_sum;
    logic [DATA_W-1:0] dxy_next;

    // NOTE: every pipeline register uses <= so all stages sample the previous
    // cycle's values on the same edge; blocking here would collapse stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q  <= '0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= bus.start;
            if (bus.start) begin
                win_q <= '{im11: bus.im11, im12: bus.im12, im13: bus.im13,
                           im21: bus.im21, im23: bus.im23,
                           im31: bus.im31, im32: bus.im32, im33: bus.im33};
            end
        end
    end

    sobel_kernel u_gx (
        .a(win_q.im13), .b(win_q.im23), .c(win_q.im33),
        .d(win_q.im11), .e(win_q.im21), .f(win_q.im31),
        .g(gx)
    );

    sobel_kernel u_gy (
        .a(win_q.im31), .b(win_q.im32), .c(win_q.im33),
        .d(win_q.im11), .e(win_q.im12), .f(win_q.im13),
        .g(gy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gx_q   <= '0;
            gy_q   <= '0;
            valid2 <= 1'b0;
        end else begin
            valid2 <= valid1;
            if (valid1) begin
                gx_q <= gx;
                gy_q <= gy;
            end
        end
    end

    // Magnitudes stay unsaturated until after the L1 sum is formed.
    assign abs_x   = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    assign abs_y   = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    assign mag_sum = wide_mag_t'(abs_x) + wide_mag_t'(abs_y);

`ifdef CANNY_THRESH_EN
    assign dxy_next = (sat_clamp(mag_sum) > THRESHOLD) ? {DATA_W{1'b1}} : '0;
`else
    assign dxy_next = sat_clamp(mag_sum);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.dx_out      <= '0;
            bus.dx_out_sign <= 1'b0;
            bus.dy_out      <= '0;
            bus.dy_out_sign <= 1'b0;
            bus.dxy         <= '0;
            bus.data_occur  <= 1'b0;
        end else begin
            bus.data_occur <= valid2;
            if (valid2) begin
                bus.dx_out      <= sat_clamp(wide_mag_t'(abs_x));
                bus.dx_out_sign <= gx_q[GRAD_W-1];
                bus.dy_out      <= sat_clamp(wide_mag_t'(abs_y));
                bus.dy_out_sign <= gy_q[GRAD_W-1];
                bus.dxy         <= dxy_next;
            end
        end
    end

endmodule

// File: tb/tb_canny_edge.sv
// Directed self-checking bench for canny_edge; expected values are hand-computed.
module tb_canny_edge;

    typedef logic [15:0] win_t [9];

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   occur_count;

    canny_edge_if bus ();

    canny_edge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected dxy from the unsaturated L1 sum.
    function automatic logic [15:0] exp_dxy(input int unsigned l1);
        logic [15:0] s;
        s = (l1 > 65535) ? 16'hFFFF : l1[15:0];
`ifdef CANNY_THRESH_EN
        return (s > 16'd128) ? 16'hFFFF : 16'h0000;
`else
        return s;
`endif
    endfunction

    // Window order: im11, im12, im13, im21, im22, im23, im31, im32, im33.
    task automatic drive(input win_t w, input logic st);
        bus.start = st;
        bus.im11 = w[0]; bus.im12 = w[1]; bus.im13 = w[2];
        bus.im21 = w[3]; bus.im22 = w[4]; bus.im23 = w[5];
        bus.im31 = w[6]; bus.im32 = w[7]; bus.im33 = w[8];
    endtask

    task automatic check_out(input string tag, input logic [15:0] dx, input logic dxs,
                             input logic [15:0] dy, input logic dys, input int unsigned l1);
        check({tag, "_dx"},  bus.dx_out,      dx);
        check({tag, "_dxs"}, bus.dx_out_sign, dxs);
        check({tag, "_dy"},  bus.dy_out,      dy);
        check({tag, "_dys"}, bus.dy_out_sign, dys);
        check({tag, "_dxy"}, bus.dxy,         exp_dxy(l1));
    endtask

    // One window with a single start pulse; result must appear exactly 2 edges later.
    task automatic run_one(input string tag, input win_t w, input logic [15:0] dx, input logic dxs,
                           input logic [15:0] dy, input logic dys, input int unsigned l1);
        @(negedge clk) drive(w, 1'b1);
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk) check({tag, "_early"}, bus.data_occur, 1'b0);
        @(negedge clk);
        check({tag, "_occur"}, bus.data_occur, 1'b1);
        check_out(tag, dx, dxs, dy, dys, l1);
        @(negedge clk);
        check({tag, "_drop"}, bus.data_occur, 1'b0);
        check({tag, "_hold"}, bus.dx_out, dx);
    endtask

    initial begin
        reset = 1'b0;
        drive('{default: 16'd0}, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_occur", bus.data_occur, 1'b0);
        check_out("rst", 16'd0, 1'b0, 16'd0, 1'b0, 0);
        reset = 1'b1;

        run_one("flat",   '{default: 16'd100}, 16'd0, 1'b0, 16'd0, 1'b0, 0);
        run_one("center", '{0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0}, 16'd0, 1'b0, 16'd0, 1'b0, 0);
        run_one("vert",   '{0, 5, 10, 0, 5, 10, 0, 5, 10}, 16'd40, 1'b0, 16'd0, 1'b0, 40);
        run_one("vswap",  '{10, 5, 0, 10, 5, 0, 10, 5, 0}, 16'd40, 1'b1, 16'd0, 1'b0, 40);
        run_one("horiz",  '{0, 0, 0, 5, 5, 5, 10, 10, 10}, 16'd0, 1'b0, 16'd40, 1'b0, 40);
        run_one("l1_200", '{0, 0, 50, 0, 0, 50, 0, 0, 50}, 16'd200, 1'b0, 16'd0, 1'b0, 200);
        run_one("sat",    '{0, 0, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 16'hFFFF},
                16'hFFFF, 1'b0, 16'd0, 1'b0, 262140);
        run_one("neg",    '{16'hC000, 0, 0, 0, 0, 0, 0, 0, 0},
                16'hC000, 1'b1, 16'hC000, 1'b1, 98304);
        run_one("corner", '{0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF},
                16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 131070);

        // Ten back-to-back windows; window k has right column k+1, so Gx = 4*(k+1).
        occur_count = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check($sformatf("stream_occur%0d", c), bus.data_occur, (c >= 3 && c <= 12));
            if (bus.data_occur) begin
                occur_count++;
                check($sformatf("stream_dx%0d", c), bus.dx_out, 4 * (c - 2));
            end
            if (c < 10) begin
                drive('{0, 0, 16'(c + 1), 0, 0, 16'(c + 1), 0, 0, 16'(c + 1)}, 1'b1);
            end else begin
                bus.start = 1'b0;
            end
        end
        check("stream_count", occur_count, 10);

        // Two windows in flight when reset hits; neither may emerge afterwards.
        @(negedge clk) drive('{0, 5, 10, 0, 5, 10, 0, 5, 10}, 1'b1);
        @(negedge clk) drive('{0, 0, 0, 5, 5, 5, 10, 10, 10}, 1'b1);
        @(negedge clk) bus.start = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("flush_occur", bus.data_occur, 1'b0);
        check_out("flush", 16'd0, 1'b0, 16'd0, 1'b0, 0);
        @(negedge clk) reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("flush_quiet%0d", c), bus.data_occur, 1'b0);
        end
        run_one("recover", '{0, 5, 10, 0, 5, 10, 0, 5, 10}, 16'd40, 1'b0, 16'd0, 1'b0, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/canny_edge.md
Name: canny_edge

Overview:
- Pipelined Sobel gradient stage of the Canny edge-detection datapath.
- Accepts one 3x3 pixel window per clock when start is high.
- Produces horizontal and vertical gradient magnitudes with sign flags, plus the combined L1 magnitude dxy.
- A data_occur strobe marks each valid result, for capture by the downstream edge writer.

Parameters:
- DATA_W, 16, pixel and output magnitude width (ports are fixed at 16 in this block; parameter exists for package consistency).
- THRESHOLD, 16'd128, edge decision level, used only when CANNY_THRESH_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  window-valid qualifier; the window is sampled on a rising edge with start=1.
- im11,im21,im31,im12,im22,im32,im13,im23,im33  input  16 each  unsigned pixels. In imRC, R is the row (1 = top) and C is the column (1 = left).
- dx_out  output  16  |Gx|, saturated.
- dx_out_sign  output  1  1 when Gx<0.
- dy_out  output  16  |Gy|, saturated.
- dy_out_sign  output  1  1 when Gy<0.
- dxy  output  16  |Gx|+|Gy|, saturated (thresholded when the feature is enabled).
- data_occur  output  1  result-valid strobe.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers cleared; dx_out=dy_out=dxy=0, both sign flags 0, data_occur=0. Reset dominates start.
- Stage 1 (edge N, start=1): capture all nine pixels and set valid1=1. If start=0, valid1=0 and the pixel registers hold their values.
- Stage 2 (edge N+1), signed 19-bit arithmetic, no overflow possible:
  - Gx = (im13+2*im23+im33) - (im11+2*im21+im31)
  - Gy = (im31+2*im32+im33) - (im11+2*im12+im13)
  - Register Gx, Gy and valid2.
- Stage 3 (edge N+2):
  - sign = MSB of each gradient.
  - Magnitude = absolute value, clamped to 0xFFFF if above 65535.
  - dxy = |Gx|+|Gy| from unsaturated 19-bit magnitudes, summed at 20 bits, clamped to 0xFFFF.
  - data_occur = valid2.
- Latency: a window sampled at edge N is visible on the outputs after edge N+2, and data_occur is high during that cycle.
- Throughput: one window per clock. A continuous start stream yields continuous data_occur after 2 cycles of fill.
- Gaps: when start drops, data_occur drops 2 cycles later. Outputs hold their last values while data_occur=0.
- Center pixel im22 does not affect the result.
- Asserting reset mid-stream flushes all in-flight windows; no data_occur pulse for them after reset release.

Optional Feature:
- CANNY_THRESH_EN defined: dxy = 16'hFFFF if the saturated magnitude sum > THRESHOLD, else 16'h0000. dx_out, dy_out and the sign flags are unchanged.
- Not defined: dxy is the saturated L1 magnitude as above; THRESHOLD is unused.

Decomposition:
- Package canny_pkg:
  - DATA_W = 16 and GRAD_W = DATA_W+3.
  - Typedef for a signed GRAD_W gradient.
  - Saturating clamp function (wide unsigned to 16 bits).
- Sub-module sobel_kernel: computes (a+2b+c)-(d+2e+f) as a signed GRAD_W result. Instantiated twice, once for Gx and once for Gy.

Test Plan:
- Flat window (all pixels 100), start=1 for one cycle -> 2 cycles later data_occur=1 for one cycle, dx_out=0, dy_out=0, dxy=0, signs 0.
- Vertical edge (left column 0, middle column 5, right column 10) -> dx_out=40, dx_out_sign=0, dy_out=0, dxy=40. With the columns swapped -> dx_out=40, dx_out_sign=1.
- Horizontal edge (top row 0, bottom row 10, middle row 5) -> dy_out=40, dy_out_sign=0, dx_out=0, dxy=40.
- Saturation (right column 0xFFFF, left column 0) -> Gx=262140, dx_out=0xFFFF, dxy=0xFFFF, sign 0.
- Ten back-to-back windows with start held high, then start=0 -> exactly 10 consecutive data_occur cycles, in order, starting at edge 2.
- Reset pulled low while 2 windows are in flight -> outputs and data_occur go to 0 immediately; no further pulses after release until start is reasserted. With CANNY_THRESH_EN defined, dxy=40 gives 0x0000 and dxy=200 gives 0xFFFF.
